// File: rtl/aidc_pkg.sv
// Shared field positions and channel typedefs for the AIDC delta codec.
package aidc_pkg;

  localparam int unsigned CHAN_W    = 32;
  localparam int unsigned VALID_BIT = 31;
  localparam int unsigned LAST_BIT  = 30;
  localparam int unsigned DATA_W    = 30;
  localparam int unsigned RESP_W    = 2;

  typedef enum logic [RESP_W-1:0] {
    RespOkay   = 2'b00,
    RespExokay = 2'b01,
    RespSlverr = 2'b10,
    RespDecerr = 2'b11
  } axi_resp_t;

  typedef struct packed {
    logic        valid;
    logic [30:0] addr;
  } axi_a_t;

  typedef struct packed {
    logic        valid;
    logic [28:0] rsvd;
    axi_resp_t   resp;
  } axi_b_t;

  typedef struct packed {
    logic              valid;
    logic              last;
    logic [DATA_W-1:0] data;
  } axi_d_t;

endpackage

// File: rtl/aidc_if.sv
// Flattened 5-channel link seen on both sides of the compressor.
interface aidc_if;
  logic [31:0] icnt_aw_intf;
  logic [31:0] icnt_w_intf;
  logic [31:0] icnt_b_intf;
  logic [31:0] icnt_ar_intf;
  logic [31:0] icnt_r_intf;
  logic [31:0] mc_aw_intf;
  logic [31:0] mc_w_intf;
  logic [31:0] mc_b_intf;
  logic [31:0] mc_ar_intf;
  logic [31:0] mc_r_intf;

  // Compressor view.
  modport slave (
    input  icnt_aw_intf, icnt_w_intf, icnt_ar_intf, mc_b_intf, mc_r_intf,
    output icnt_b_intf, icnt_r_intf, mc_aw_intf, mc_w_intf, mc_ar_intf
  );

  // Environment view (interconnect plus memory controller).
  modport master (
    output icnt_aw_intf, icnt_w_intf, icnt_ar_intf, mc_b_intf, mc_r_intf,
    input  icnt_b_intf, icnt_r_intf, mc_aw_intf, mc_w_intf, mc_ar_intf
  );
endinterface

// File: rtl/aidc_xor_codec.sv
// Per-burst XOR delta codec; DECODE=0 encodes raw beats, DECODE=1 restores them.
module aidc_xor_codec
  import aidc_pkg::*;
#(
  parameter bit DECODE = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_enable,
  input  logic [31:0] i_beat,
  output logic [31:0] o_beat
);

  axi_d_t              w_in;
  axi_d_t              w_out_nxt;
  logic                w_en_eff;
  logic [DATA_W-1:0]   w_xor;
  logic [DATA_W-1:0]   w_prev_nxt;
  logic                w_burst_nxt;
  logic                w_en_nxt;

  axi_d_t              r_out;
  logic [DATA_W-1:0]   r_prev;
  logic                r_in_burst;
  logic                r_en;

  assign w_in     = i_beat;
  // Enable is only sampled on the first beat; later beats reuse the latched value.
  assign w_en_eff = r_in_burst ? r_en : i_enable;
  assign w_xor    = w_in.data ^ r_prev;
  assign o_beat   = r_out;

  always_comb begin
    w_out_nxt   = '0;
    w_prev_nxt  = r_prev;
    w_burst_nxt = r_in_burst;
    w_en_nxt    = r_en;
    if (w_in.valid) begin
      w_burst_nxt = ~w_in.last;
      w_en_nxt    = w_en_eff;
      if (w_en_eff) begin
        w_out_nxt.valid = 1'b1;
        w_out_nxt.last  = w_in.last;
        w_out_nxt.data  = w_xor;
        // Both sides chain on the raw (decoded) value.
        w_prev_nxt      = DECODE ? w_xor : w_in.data;
      end else begin
        w_out_nxt = w_in;
      end
      if (w_in.last) begin
        w_prev_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_out      <= '0;
      r_prev     <= '0;
      r_in_burst <= 1'b0;
      r_en       <= 1'b0;
    end else begin
      r_out      <= w_out_nxt;
      r_prev     <= w_prev_nxt;
      r_in_burst <= w_burst_nxt;
      r_en       <= w_en_nxt;
    end
  end

endmodule

// File: rtl/aidc_top.sv
// AI data compressor: XOR delta codec on W/R, 1-cycle retiming on AW/AR/B.
module aidc_top
  import aidc_pkg::*;
#(
  parameter int unsigned PARAM = CHAN_W
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  ENABLE_i,
  aidc_if.slave bus
);

  logic [PARAM-1:0] r_aw;
  logic [PARAM-1:0] r_ar;
  axi_b_t           r_b;
  axi_b_t           w_b_nxt;
  axi_a_t           w_aw_in;
  axi_a_t           w_ar_in;

  assign w_aw_in = bus.icnt_aw_intf;
  assign w_ar_in = bus.icnt_ar_intf;

  // Reserved response bits are forced to zero toward the interconnect.
  always_comb begin
    w_b_nxt = '0;
    if (bus.mc_b_intf[VALID_BIT]) begin
      w_b_nxt.valid = 1'b1;
      w_b_nxt.resp  = axi_resp_t'(bus.mc_b_intf[RESP_W-1:0]);
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_aw <= '0;
      r_ar <= '0;
      r_b  <= '0;
    end else begin
      r_aw <= w_aw_in.valid ? w_aw_in : '0;
      r_ar <= w_ar_in.valid ? w_ar_in : '0;
      r_b  <= w_b_nxt;
    end
  end

  assign bus.mc_aw_intf  = r_aw;
  assign bus.mc_ar_intf  = r_ar;
  assign bus.icnt_b_intf = r_b;

  aidc_xor_codec #(
    .DECODE (1'b0)
  ) u_w_enc (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_enable (ENABLE_i),
    .i_beat   (bus.icnt_w_intf),
    .o_beat   (bus.mc_w_intf)
  );

  aidc_xor_codec #(
    .DECODE (1'b1)
  ) u_r_dec (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_enable (ENABLE_i),
    .i_beat   (bus.mc_r_intf),
    .o_beat   (bus.icnt_r_intf)
  );

endmodule

// File: tb/tb_aidc_top.sv
// Bench for aidc_top: directed vector table, reset corner cases, randomized burst traffic.
module tb_aidc_top;

  logic clk;
  logic rst_n;
  logic enable;
  int   n_tests;
  int   n_fail;

  aidc_if bus ();

  aidc_top dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ENABLE_i (enable),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [31:0] aw, w, ar, b, r;
    logic [31:0] e_aw, e_w, e_ar, e_b, e_r;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [31:0] aw, input logic [31:0] w,
                       input logic [31:0] ar, input logic [31:0] b, input logic [31:0] r);
    enable           = en;
    bus.icnt_aw_intf = aw;
    bus.icnt_w_intf  = w;
    bus.icnt_ar_intf = ar;
    bus.mc_b_intf    = b;
    bus.mc_r_intf    = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_aw, input logic [31:0] e_w,
                         input logic [31:0] e_ar, input logic [31:0] e_b,
                         input logic [31:0] e_r);
    chk({tag, ".mc_aw"}, bus.mc_aw_intf, e_aw);
    chk({tag, ".mc_w"}, bus.mc_w_intf, e_w);
    chk({tag, ".mc_ar"}, bus.mc_ar_intf, e_ar);
    chk({tag, ".icnt_b"}, bus.icnt_b_intf, e_b);
    chk({tag, ".icnt_r"}, bus.icnt_r_intf, e_r);
  endtask

  // Reference model state: per-burst history of raw W data and received R deltas.
  logic [29:0] m_w_hist[$];
  logic [29:0] m_r_enc[$];
  bit          m_w_open, m_w_en, m_r_open, m_r_en;

  function automatic logic [31:0] model_w(input logic en, input logic [31:0] beat);
    logic [29:0] prev;
    logic [31:0] res;
    if (!beat[31]) return 32'h0;
    if (!m_w_open) begin
      m_w_en = en;
      m_w_hist.delete();
    end
    prev = (m_w_hist.size() > 0) ? m_w_hist[m_w_hist.size()-1] : 30'h0;
    res  = m_w_en ? {1'b1, beat[30], beat[29:0] ^ prev} : beat;
    m_w_hist.push_back(beat[29:0]);
    m_w_open = !beat[30];
    return res;
  endfunction

  // Decoded value is the XOR of every delta received so far in the burst.
  function automatic logic [31:0] model_r(input logic en, input logic [31:0] beat);
    logic [29:0] acc;
    if (!beat[31]) return 32'h0;
    if (!m_r_open) begin
      m_r_en = en;
      m_r_enc.delete();
    end
    m_r_open = !beat[30];
    if (!m_r_en) return beat;
    m_r_enc.push_back(beat[29:0]);
    acc = 30'h0;
    foreach (m_r_enc[k]) acc ^= m_r_enc[k];
    return {1'b1, beat[30], acc};
  endfunction

  initial begin
    logic [31:0] e_aw, e_w, e_ar, e_b, e_r;
    logic [31:0] s_aw, s_w, s_ar, s_b, s_r;
    logic        s_en;
    n_tests = 0;
    n_fail  = 0;

    tbl[0]  = '{1'b0, 32'h8000_1000, 32'h8000_00FF, 32'h0, 32'h0, 32'h0,
                32'h8000_1000, 32'h8000_00FF, 32'h0, 32'h0, 32'h0};
    tbl[1]  = '{1'b1, 32'h0000_1234, 32'h0000_0055, 32'h8000_2000, 32'h8000_0002, 32'h0,
                32'h0, 32'h0, 32'h8000_2000, 32'h8000_0002, 32'h0};
    tbl[2]  = '{1'b1, 32'h0, 32'h8000_0003, 32'h0000_0001, 32'h8123_4561, 32'h0,
                32'h0, 32'h8000_0003, 32'h0, 32'h8000_0001, 32'h0};
    tbl[3]  = '{1'b1, 32'h0, 32'hC000_0001, 32'h0, 32'h0, 32'h0,
                32'h0, 32'hC000_0001, 32'h0, 32'h0, 32'h0};
    tbl[4]  = '{1'b1, 32'h0, 32'h8000_0005, 32'h0, 32'h0, 32'h8000_0005,
                32'h0, 32'h8000_0005, 32'h0, 32'h0, 32'h8000_0005};
    tbl[5]  = '{1'b0, 32'h0, 32'hC000_0007, 32'h0, 32'h0, 32'hC000_0002,
                32'h0, 32'hC000_0002, 32'h0, 32'h0, 32'hC000_0007};
    tbl[6]  = '{1'b1, 32'h0, 32'hC000_0009, 32'h0, 32'h0, 32'hC000_000A,
                32'h0, 32'hC000_0009, 32'h0, 32'h0, 32'hC000_000A};
    tbl[7]  = '{1'b1, 32'h0, 32'h8000_0010, 32'h0, 32'h0, 32'h8000_0001,
                32'h0, 32'h8000_0010, 32'h0, 32'h0, 32'h8000_0001};
    tbl[8]  = '{1'b1, 32'h0, 32'h0000_0077, 32'h0, 32'h0, 32'h0000_0099,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[9]  = '{1'b1, 32'h0, 32'hC000_0011, 32'h0, 32'h0, 32'hC000_0003,
                32'h0, 32'hC000_0001, 32'h0, 32'h0, 32'hC000_0002};
    tbl[10] = '{1'b1, 32'h0, 32'hBFFF_FFFF, 32'h0, 32'h0, 32'hBFFF_FFFF,
                32'h0, 32'hBFFF_FFFF, 32'h0, 32'h0, 32'hBFFF_FFFF};
    tbl[11] = '{1'b1, 32'h0, 32'hC000_0000, 32'h0, 32'h0, 32'hC000_0000,
                32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'hFFFF_FFFF};

    // Reset holds every output at zero even with valid traffic present.
    rst_n = 1'b1;
    drive(1'b1, 32'h8000_0001, 32'h8000_0002, 32'h8000_0003, 32'h8000_0001, 32'h8000_0004);
    tick();
    tick();
    chk_all("reset", 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    rst_n = 1'b0;
    tick();
    chk_all("idle", 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].en, tbl[i].aw, tbl[i].w, tbl[i].ar, tbl[i].b, tbl[i].r);
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].e_aw, tbl[i].e_w, tbl[i].e_ar, tbl[i].e_b,
              tbl[i].e_r);
    end

    // Async reset mid-burst: outputs clear at once, next beat starts a fresh burst.
    drive(1'b1, 32'h0, 32'h8000_0005, 32'h0, 32'h0, 32'h8000_0005);
    tick();
    chk("rstmid.pre_w", bus.mc_w_intf, 32'h8000_0005);
    drive(1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    rst_n = 1'b1;
    #1;
    chk_all("rstmid.async", 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    #1;
    rst_n = 1'b0;
    drive(1'b1, 32'h0, 32'hC000_0007, 32'h0, 32'h0, 32'hC000_0002);
    tick();
    chk("rstmid.post_w", bus.mc_w_intf, 32'hC000_0007);
    chk("rstmid.post_r", bus.icnt_r_intf, 32'hC000_0002);

    // Randomized traffic against the burst-level model.
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    m_w_open = 1'b0;
    m_r_open = 1'b0;
    m_w_en   = 1'b0;
    m_r_en   = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      s_en = ($urandom_range(0, 1) == 1);
      s_aw = $urandom();
      s_ar = $urandom();
      s_b  = $urandom();
      s_w  = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), 30'($urandom())};
      s_r  = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), 30'($urandom())};
      e_aw = s_aw[31] ? s_aw : 32'h0;
      e_ar = s_ar[31] ? s_ar : 32'h0;
      e_b  = s_b[31] ? {1'b1, 29'h0, s_b[1:0]} : 32'h0;
      e_w  = model_w(s_en, s_w);
      e_r  = model_r(s_en, s_r);
      drive(s_en, s_aw, s_w, s_ar, s_b, s_r);
      tick();
      chk_all($sformatf("rnd%0d", c), e_aw, e_w, e_ar, e_b, e_r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
